multi_ch_fsize_fifo: RTL and testbench

Multi-channel fixed-latency FIFO: `NCH` independent channels, each buffering a write stream and replaying it at a constant delay of `RD_THR` cycles once primed. It is the parametrised successor of the single-channel fixed-size FIFO and sits in front of per-channel consumers that need deterministic alignment. It adds channel count, stall (`HOLD`), flush, and sticky overflow/underflow reporting.

---
 rtl/fsize_fifo_pkg.sv | 20 ++
 rtl/fsize_fifo_ch.sv | 114 +++++++++++
 rtl/multi_ch_fsize_fifo.sv | 46 ++++
 tb/tb_multi_ch_fsize_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fsize_fifo_pkg.sv
// Shared types and helpers for the multi-channel fixed-latency FIFO.
// Holds the per-channel state encoding and the occupancy-counter width helper.
package fsize_fifo_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } fifo_state_t;

  // Smallest bit count able to represent values 0..value-1.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fsize_fifo_ch.sv
// One fixed-latency FIFO channel: buffers a write stream and replays it
// RD_THR cycles later once primed, with sticky overflow/underflow flags.
module fsize_fifo_ch
  import fsize_fifo_pkg::*;
#(
  parameter int DW      = 32,
  parameter int LEN_LOG = 12,
  parameter int RD_THR  = 3000
) (
  input  logic          i_clk,
  input  logic          i_rst_x,
  input  logic          i_flush,
  input  logic          i_hold,
  input  logic          i_enq,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dot,
  output logic          o_dvld,
  output logic          o_ovf,
  output logic          o_unf
);

  localparam int DEPTH = 2 ** LEN_LOG;
  localparam int CNT_W = clog2(DEPTH + 1);

  if (RD_THR < 1 || RD_THR > DEPTH) begin : g_bad_thr
    $error("fsize_fifo_ch: RD_THR must lie in 1..2**LEN_LOG");
  end

  logic [DW-1:0]      r_mem [DEPTH];
  logic [LEN_LOG-1:0] r_wptr;
  logic [LEN_LOG-1:0] r_rptr;
  logic [CNT_W-1:0]   r_cnt;
  fifo_state_t        r_state;
  logic [DW-1:0]      r_dot;
  logic               r_dvld;
  logic               r_ovf;
  logic               r_unf;

  logic               w_full;
  logic               w_empty;
  logic               w_streaming;
  logic               w_pop;
  logic               w_push;
  logic               w_ovf;
  logic               w_unf;
  logic               w_clear;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_full      = (r_cnt == CNT_W'(DEPTH));
  assign w_empty     = (r_cnt == '0);
  assign w_streaming = (r_state == STREAM);
  assign w_pop       = w_streaming && !i_hold && !w_empty;
  assign w_unf       = w_streaming && !i_hold && w_empty;
  // A full channel still accepts a word when a pop frees a slot in the same cycle.
  assign w_push      = i_enq && (!w_full || w_pop);
  assign w_ovf       = i_enq && w_full && !w_pop;
  assign w_clear     = !i_rst_x || i_flush;
  assign w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, w_push} - {{(CNT_W-1){1'b0}}, w_pop};

  always_ff @(posedge i_clk) begin
    if (w_push && !w_clear) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_state <= FILL;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_dot   <= '0;
      r_dvld  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + LEN_LOG'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + LEN_LOG'(1);
        r_dot  <= r_mem[r_rptr];
      end
      r_dvld <= w_pop;
      r_cnt  <= w_cnt_nxt;
      if (w_ovf) begin
        r_ovf <= 1'b1;
      end
      if (w_unf) begin
        r_unf <= 1'b1;
      end
      // Priming compares the post-edge count so the first pop lands RD_THR edges after the first write.
      case (r_state)
        FILL: begin
          if (w_cnt_nxt >= CNT_W'(RD_THR)) begin
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_unf) begin
            r_state <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign o_dot  = r_dot;
  assign o_dvld = r_dvld;
  assign o_ovf  = r_ovf;
  assign o_unf  = r_unf;

endmodule

// File: rtl/multi_ch_fsize_fifo.sv
// Multi-channel fixed-latency FIFO: NCH independent channels sharing only
// clock, reset, FLUSH and the global HOLD stall.
module multi_ch_fsize_fifo
  import fsize_fifo_pkg::*;
#(
  parameter int DW      = 32,
  parameter int NCH     = 4,
  parameter int LEN_LOG = 12,
  parameter int RD_THR  = 3000
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              FLUSH,
  input  logic              HOLD,
  input  logic [NCH-1:0]    ENQ,
  input  logic [NCH*DW-1:0] DIN,
  output logic [NCH*DW-1:0] DOT,
  output logic [NCH-1:0]    DVLD,
  output logic [NCH-1:0]    OVF,
  output logic [NCH-1:0]    UNF
);

  if (NCH < 1) begin : g_bad_nch
    $error("multi_ch_fsize_fifo: NCH must be at least 1");
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    fsize_fifo_ch #(
      .DW      (DW),
      .LEN_LOG (LEN_LOG),
      .RD_THR  (RD_THR)
    ) u_ch (
      .i_clk   (CLK),
      .i_rst_x (RST_X),
      .i_flush (FLUSH),
      .i_hold  (HOLD),
      .i_enq   (ENQ[c]),
      .i_din   (DIN[c*DW +: DW]),
      .o_dot   (DOT[c*DW +: DW]),
      .o_dvld  (DVLD[c]),
      .o_ovf   (OVF[c]),
      .o_unf   (UNF[c])
    );
  end

endmodule

// File: tb/tb_multi_ch_fsize_fifo.sv
// Directed-vector bench for multi_ch_fsize_fifo: latency, underflow, overflow
// under HOLD, flush, mid-run reset and channel independence.
module tb_multi_ch_fsize_fifo;

  localparam int DW      = 8;
  localparam int NCH     = 2;
  localparam int LEN_LOG = 4;
  localparam int RD_THR  = 10;

  typedef struct {
    logic              rstX;
    logic              flush;
    logic              hold;
    logic [NCH-1:0]    enq;
    logic [NCH*DW-1:0] din;
    logic [NCH*DW-1:0] expDot;
    logic [NCH-1:0]    expDvld;
    logic [NCH-1:0]    expOvf;
    logic [NCH-1:0]    expUnf;
  } vec_t;

  logic              clk;
  logic              rstX;
  logic              flush;
  logic              hold;
  logic [NCH-1:0]    enq;
  logic [NCH*DW-1:0] din;
  logic [NCH*DW-1:0] dot;
  logic [NCH-1:0]    dvld;
  logic [NCH-1:0]    ovf;
  logic [NCH-1:0]    unf;

  vec_t vecs[$];
  int   vecCount;
  int   missCount;

  multi_ch_fsize_fifo #(
    .DW      (DW),
    .NCH     (NCH),
    .LEN_LOG (LEN_LOG),
    .RD_THR  (RD_THR)
  ) dut (
    .CLK   (clk),
    .RST_X (rstX),
    .FLUSH (flush),
    .HOLD  (hold),
    .ENQ   (enq),
    .DIN   (din),
    .DOT   (dot),
    .DVLD  (dvld),
    .OVF   (ovf),
    .UNF   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input logic r, input logic f, input logic h,
                                 input logic [1:0] e, input int d0, input int d1,
                                 input int x0, input int x1, input logic [1:0] v,
                                 input logic [1:0] o, input logic [1:0] u);
    vec_t t;
    t.rstX    = r;
    t.flush   = f;
    t.hold    = h;
    t.enq     = e;
    t.din     = {DW'(d1), DW'(d0)};
    t.expDot  = {DW'(x1), DW'(x0)};
    t.expDvld = v;
    t.expOvf  = o;
    t.expUnf  = u;
    vecs.push_back(t);
  endfunction

  task automatic applyStimulus(input vec_t v);
    rstX  = v.rstX;
    flush = v.flush;
    hold  = v.hold;
    enq   = v.enq;
    din   = v.din;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    vecCount++;
    if (dot !== v.expDot || dvld !== v.expDvld || ovf !== v.expOvf || unf !== v.expUnf) begin
      missCount++;
      $display("[TB] FAIL vec%0d: dot=%h dvld=%b ovf=%b unf=%b, expected dot=%h dvld=%b ovf=%b unf=%b",
               idx, dot, dvld, ovf, unf, v.expDot, v.expDvld, v.expOvf, v.expUnf);
    end
  endtask

  task automatic checkScalar(input string name, input int actual, input int expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    int  n;
    logic found;

    vecCount  = 0;
    missCount = 0;
    rstX  = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    enq   = '0;
    din   = '0;

    // Latency, underflow with no-bypass re-enqueue, then flush and refill on ch0.
    addVec(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k <= 14; k++)
      addVec(1, 0, 0, 2'b01, k, 0, (k >= 10) ? k - 10 : 0, 0, {1'b0, k >= 10}, 2'b00, 2'b00);
    for (int k = 15; k <= 24; k++)
      addVec(1, 0, 0, 2'b00, 0, 0, k - 10, 0, 2'b01, 2'b00, 2'b00);
    for (int k = 25; k <= 34; k++)
      addVec(1, 0, 0, 2'b01, 100 + k - 25, 0, 14, 0, 2'b00, 2'b00, 2'b01);
    for (int k = 35; k <= 38; k++)
      addVec(1, 0, 0, 2'b00, 0, 0, 100 + k - 35, 0, 2'b01, 2'b00, 2'b01);
    addVec(1, 1, 0, 2'b11, 8'hEE, 8'hEE, 0, 0, 2'b00, 2'b00, 2'b00);
    for (int k = 40; k <= 51; k++)
      addVec(1, 0, 0, 2'b01, 200 + k - 40, 0, (k >= 50) ? 200 + k - 50 : 0, 0,
             {1'b0, k >= 50}, 2'b00, 2'b00);

    // Overflow while stalled: words 18 and 19 are dropped, then reset mid-stream.
    addVec(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k <= 11; k++)
      addVec(1, 0, 0, 2'b01, k, 0, (k >= 10) ? k - 10 : 0, 0, {1'b0, k >= 10}, 2'b00, 2'b00);
    for (int k = 12; k <= 19; k++)
      addVec(1, 0, 1, 2'b01, k, 0, 1, 0, 2'b00, {1'b0, k >= 18}, 2'b00);
    for (int k = 20; k <= 40; k++)
      addVec(1, 0, 0, 2'b01, k, 0, (k <= 35) ? k - 18 : k - 16, 0, 2'b01, 2'b01, 2'b00);
    addVec(0, 0, 0, 2'b11, 8'h55, 8'h55, 0, 0, 2'b00, 2'b00, 2'b00);
    addVec(1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);

    // Independence: ch1 starts five cycles after ch0.
    addVec(0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    for (int k = 0; k <= 19; k++)
      addVec(1, 0, 0, {k >= 5, 1'b1}, k, (k >= 5) ? 50 + k - 5 : 0,
             (k >= 10) ? k - 10 : 0, (k >= 15) ? 50 + k - 15 : 0,
             {k >= 15, k >= 10}, 2'b00, 2'b00);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // ch1 latency measured with a bounded wait, then a 3-cycle HOLD.
    rstX  = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    enq   = '0;
    @(posedge clk);
    #1;
    rstX  = 1'b1;
    n     = 0;
    found = 1'b0;
    while (n < 40 && !found) begin
      enq = 2'b10;
      din = {8'h30 + 8'(n), 8'h00};
      @(posedge clk);
      #1;
      if (dvld[1]) found = 1'b1;
      else n++;
    end
    checkScalar("ch1_latency", n, RD_THR);
    checkScalar("ch1_first_word", int'(dot[15:8]), 8'h30);
    enq  = 2'b00;
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(posedge clk);
      #1;
      checkScalar("hold_dvld", int'(dvld), 0);
      checkScalar("hold_dot", int'(dot[15:8]), 8'h30);
    end
    hold = 1'b0;
    @(posedge clk);
    #1;
    checkScalar("resume_dvld", int'(dvld), 2);
    checkScalar("resume_dot", int'(dot[15:8]), 8'h31);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
